ssg_scan_reader: RTL and testbench
==================================

SSG_SCAN_READER -- requirements
Module: ssg_scan_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before capture; legal range is 2..255.
REQ-002 Parameter CNT_W, default $clog2(STABLE_CYCLES+1), is the stability counter width; it is derived and never overridden.
REQ-003 clk  input  1  is the single clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 SSG_D  input  7  carries the segment pattern: active-low, bit0=a .. bit6=g, so '0' is 7'b1000000.
REQ-006 SSG_EN  input  4  carries the digit enables: active-low, bit n selects digit n.
REQ-007 err_clr  input  1  is a one-cycle pulse that clears both sticky error flags.
REQ-008 digits  output  16  holds the captured values, 4 bits per digit; digit n is at [4n+3:4n].
REQ-009 digit_valid  output  4  bit n is 1 when digit n last captured a numeric pattern.
REQ-010 frame_done  output  1  is a one-cycle pulse emitted when all 4 digits have been captured since the previous pulse.
REQ-011 seg_err  output  1  is a sticky flag set when a stable pattern is not decodable.
REQ-012 en_err  output  1  is a sticky flag set when more than one SSG_EN bit is low in the same cycle.

Function
REQ-013 SSG_D and SSG_EN shall be registered once before use; all timing below refers to these registered copies.
REQ-014 The FSM shall have three states: IDLE, SETTLE and CAPTURED.
REQ-015 IDLE: when exactly one enable is low, go to SETTLE, latch the enable and the pattern, and set cnt=1; otherwise stay in IDLE.
REQ-016 SETTLE: if the enable and pattern are unchanged, increment cnt; when cnt reaches STABLE_CYCLES, capture and go to CAPTURED.
REQ-017 SETTLE or CAPTURED: on any change in the enable or pattern, go to SETTLE with cnt=1 if exactly one enable is low, else go to IDLE.
REQ-018 Pin-to-output latency shall be STABLE_CYCLES+1 cycles; each hold period produces exactly one capture, with no re-capture while the inputs stay unchanged.
REQ-019 A numeric capture (0-9) shall write the BCD value into the selected digit, set digit_valid[n] and set seen[n].
REQ-020 A blank capture (7'b1111111) shall write 4'hF, clear digit_valid[n] and set seen[n].
REQ-021 An undecodable capture shall leave the digit and digit_valid unchanged, leave seen[n] clear and set seg_err.
REQ-022 Two or more enables low in one cycle shall set en_err and force IDLE.
REQ-023 When seen becomes 4'b1111, frame_done shall pulse in the cycle after the capture edge, and seen shall clear in that same cycle.
REQ-024 If err_clr arrives in the same cycle as a new error, the set shall win and the flag stays 1.
REQ-025 Recapturing an already-seen digit before the frame completes shall overwrite the value and shall not pulse frame_done.

Reset
REQ-026 On reset the outputs shall be: digits=16'hFFFF, digit_valid=0, frame_done=0, seg_err=0, en_err=0.
REQ-027 On reset the internal state shall be: FSM=IDLE, cnt=0, seen=0, input registers=all ones.
REQ-028 Reset asserted mid-SETTLE shall discard the partial count; no capture shall occur from that hold.

Configuration
REQ-029 The macro SSG_SCAN_READER_HEX_EN shall control decoding of the hex letter patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110 and F=0001110.
REQ-030 With the macro defined, those patterns shall decode to 4'hA..4'hF and set digit_valid[n].
REQ-031 Without the macro, those patterns shall be undecodable, so their capture sets seg_err per REQ-021.

Structure
REQ-032 Package ssg_pkg shall hold the FSM state enum, the 0-9 and A-F pattern constants, SEG_BLANK=7'b1111111 and DIGIT_BLANK=4'hF.
REQ-033 Sub-module ssg_pat_decode shall be combinational, mapping a 7-bit pattern to a 4-bit value plus is_num, is_blank and is_err.
REQ-034 All sequential logic shall reside in ssg_scan_reader.

Verification
REQ-035 Reset test: after reset, digits=FFFF, digit_valid=0, both error flags=0 and frame_done never pulses.
REQ-036 Scan test: hold SSG_EN=1110 with SSG_D=1111001 for 4 cycles, then 1101 with 0100100, 1011 with 0110000, 0111 with 0011001 -> digits=16'h4321, digit_valid=1111, one frame_done pulse 5 cycles after the last hold starts.
REQ-037 Settle test: hold 1110 with 0010010 for 3 cycles, then change to 0000010 for 4 cycles -> digit0=6, never 5.
REQ-038 Collision test: SSG_EN=1100 for one cycle -> en_err=1 and FSM returns to IDLE; an err_clr in the same cycle as a further collision keeps en_err=1.
REQ-039 Hex test: hold 1110 with 0001000 for 4 cycles -> with the macro defined, digit0=A and digit_valid[0]=1; without it, seg_err=1 and digit0 is unchanged.
REQ-040 Blank test: hold 1101 with 1111111 for 4 cycles -> digit1=F, digit_valid[1]=0 and seen[1] set toward frame_done.

Source files
------------

// File: rtl/ssg_pkg.sv
// Shared types and constants for the seven-segment scan reader.
// Segment patterns are active-low, bit0 = segment a .. bit6 = segment g.
package ssg_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned EN_W    = 4;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned NUM_DIG = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURED = 2'd2
   } ssg_state_e;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

   localparam logic [SEG_W-1:0] SEG_BLANK   = 7'b1111111;
   localparam logic [DIG_W-1:0] DIGIT_BLANK = 4'hF;

   // Number of asserted (low) digit enables in one sample.
   function automatic logic [2:0] low_count(input logic [EN_W-1:0] en);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < int'(EN_W); i++) begin
         n = n + 3'(!en[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/ssg_pat_decode.sv
// Combinational seven-segment pattern to BCD/hex decoder.
// Letter patterns A..F decode only when SSG_SCAN_READER_HEX_EN is defined.
module ssg_pat_decode
   import ssg_pkg::*;
(
   input  logic [SEG_W-1:0] i_pat,
   output logic [DIG_W-1:0] o_val_c,
   output logic             o_is_num_c,
   output logic             o_is_blank_c,
   output logic             o_is_err_c
);

   always_comb begin
      o_val_c      = DIGIT_BLANK;
      o_is_blank_c = 1'b0;
      o_is_err_c   = 1'b0;
      case (i_pat)
         SEG_0:     o_val_c = 4'h0;
         SEG_1:     o_val_c = 4'h1;
         SEG_2:     o_val_c = 4'h2;
         SEG_3:     o_val_c = 4'h3;
         SEG_4:     o_val_c = 4'h4;
         SEG_5:     o_val_c = 4'h5;
         SEG_6:     o_val_c = 4'h6;
         SEG_7:     o_val_c = 4'h7;
         SEG_8:     o_val_c = 4'h8;
         SEG_9:     o_val_c = 4'h9;
`ifdef SSG_SCAN_READER_HEX_EN
         SEG_A:     o_val_c = 4'hA;
         SEG_B:     o_val_c = 4'hB;
         SEG_C:     o_val_c = 4'hC;
         SEG_D:     o_val_c = 4'hD;
         SEG_E:     o_val_c = 4'hE;
         SEG_F:     o_val_c = 4'hF;
`endif
         SEG_BLANK: o_is_blank_c = 1'b1;
         default:   o_is_err_c   = 1'b1;
      endcase
      o_is_num_c = !o_is_blank_c && !o_is_err_c;
   end

endmodule

// File: rtl/ssg_scan_reader.sv
// Samples a multiplexed 4-digit seven-segment display bus and captures each
// digit once its pattern has been stable for STABLE_CYCLES samples.
// Hex letter decoding is enabled by defining SSG_SCAN_READER_HEX_EN.
module ssg_scan_reader
   import ssg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SEG_W-1:0]         SSG_D,
   input  logic [EN_W-1:0]          SSG_EN,
   input  logic                     err_clr,
   output logic [NUM_DIG*DIG_W-1:0] digits,
   output logic [NUM_DIG-1:0]       digit_valid,
   output logic                     frame_done,
   output logic                     seg_err,
   output logic                     en_err
);

   logic [SEG_W-1:0]   r_d;
   logic [EN_W-1:0]    r_en;
   ssg_state_e         r_state;
   ssg_state_e         w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [EN_W-1:0]    r_lat_en;
   logic [EN_W-1:0]    w_lat_en_nxt;
   logic [SEG_W-1:0]   r_lat_d;
   logic [SEG_W-1:0]   w_lat_d_nxt;
   logic [NUM_DIG-1:0] r_seen;

   logic               w_one_low;
   logic               w_multi_low;
   logic               w_changed;
   logic               w_capture;
   logic [DIG_W-1:0]   w_dec_val;
   logic               w_dec_num;
   logic               w_dec_blank;
   logic               w_dec_err;
   logic [NUM_DIG-1:0] w_sel;
   logic [NUM_DIG-1:0] w_seen_set;
   logic [NUM_DIG-1:0] w_seen_acc;

   assign w_one_low   = (low_count(r_en) == 3'd1);
   assign w_multi_low = (low_count(r_en) > 3'd1);
   assign w_changed   = (r_en != r_lat_en) || (r_d != r_lat_d);

   // The latched enable is one-hot low whenever a capture can happen.
   assign w_sel       = ~r_lat_en;
   assign w_seen_set  = (w_dec_num || w_dec_blank) ? w_sel : '0;
   assign w_seen_acc  = r_seen | w_seen_set;

   ssg_pat_decode u_decode (
      .i_pat        (r_lat_d),
      .o_val_c      (w_dec_val),
      .o_is_num_c   (w_dec_num),
      .o_is_blank_c (w_dec_blank),
      .o_is_err_c   (w_dec_err)
   );

   // Stability tracking: next state, counter and latched sample.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_lat_en_nxt = r_lat_en;
      w_lat_d_nxt  = r_lat_d;
      w_capture    = 1'b0;
      if (w_multi_low) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_one_low) begin
                  w_state_nxt  = ST_SETTLE;
                  w_cnt_nxt    = CNT_W'(1);
                  w_lat_en_nxt = r_en;
                  w_lat_d_nxt  = r_d;
               end
            end
            ST_SETTLE, ST_CAPTURED: begin
               if (w_changed) begin
                  if (w_one_low) begin
                     w_state_nxt  = ST_SETTLE;
                     w_cnt_nxt    = CNT_W'(1);
                     w_lat_en_nxt = r_en;
                     w_lat_d_nxt  = r_d;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end
               end else if (r_state == ST_SETTLE) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                     w_state_nxt = ST_CAPTURED;
                     w_capture   = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_d      <= SEG_BLANK;
         r_en     <= '1;
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_lat_en <= '1;
         r_lat_d  <= SEG_BLANK;
      end else begin
         r_d      <= SSG_D;
         r_en     <= SSG_EN;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_lat_en <= w_lat_en_nxt;
         r_lat_d  <= w_lat_d_nxt;
      end
   end

   // Capture results, frame tracking and sticky errors (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         digits      <= {NUM_DIG{DIGIT_BLANK}};
         digit_valid <= '0;
         frame_done  <= 1'b0;
         seg_err     <= 1'b0;
         en_err      <= 1'b0;
         r_seen      <= '0;
      end else begin
         frame_done <= 1'b0;
         if (w_capture) begin
            for (int n = 0; n < int'(NUM_DIG); n++) begin
               if (w_sel[n] && (w_dec_num || w_dec_blank)) begin
                  digits[n*DIG_W +: DIG_W] <= w_dec_num ? w_dec_val : DIGIT_BLANK;
                  digit_valid[n]           <= w_dec_num;
               end
            end
            if (&w_seen_acc) begin
               frame_done <= 1'b1;
               r_seen     <= '0;
            end else begin
               r_seen <= w_seen_acc;
            end
         end
         seg_err <= (w_capture && w_dec_err) || (seg_err && !err_clr);
         en_err  <= w_multi_low || (en_err && !err_clr);
      end
   end

endmodule

// File: tb/tb_ssg_scan_reader.sv
// Scoreboard bench for ssg_scan_reader: each expected capture is queued when
// its hold is driven and compared when the capture latency has elapsed.
module tb_ssg_scan_reader;

   localparam int STABLE = 4;

   logic        clk;
   logic        reset;
   logic [6:0]  SSG_D;
   logic [3:0]  SSG_EN;
   logic        err_clr;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        seg_err;
   logic        en_err;

   ssg_scan_reader #(.STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .reset       (reset),
      .SSG_D       (SSG_D),
      .SSG_EN      (SSG_EN),
      .err_clr     (err_clr),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .seg_err     (seg_err),
      .en_err      (en_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [15:0] dig;
      logic [3:0]  val;
      logic        serr;
      logic        frame;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [15:0] m_dig;
   logic [3:0]  m_val;
   logic [3:0]  m_seen;
   logic        m_serr;
   int          total = 0;
   int          bad   = 0;
   int          frames = 0;
   bit          saw5 = 0;

   always @(negedge clk) if (frame_done === 1'b1) frames++;
   always @(negedge clk) if (digits[3:0] === 4'h5) saw5 = 1;

   // Scoreboard pop: compare the queued expectation at its due cycle.
   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         total += 4;
         if (digits !== e.dig) begin
            bad++; $display("FAIL sb_digits cyc=%0d got=%h exp=%h", cyc, digits, e.dig);
         end
         if (digit_valid !== e.val) begin
            bad++; $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, digit_valid, e.val);
         end
         if (seg_err !== e.serr) begin
            bad++; $display("FAIL sb_seg_err cyc=%0d got=%b exp=%b", cyc, seg_err, e.serr);
         end
         if (frame_done !== e.frame) begin
            bad++; $display("FAIL sb_frame cyc=%0d got=%b exp=%b", cyc, frame_done, e.frame);
         end
      end
   end

   // Reference decode: 0 numeric, 1 blank, 2 undecodable.
   function automatic int ref_kind(input logic [6:0] d, output logic [3:0] v);
      v = 4'hF;
      case (d)
         7'b1000000: begin v = 4'h0; return 0; end
         7'b1111001: begin v = 4'h1; return 0; end
         7'b0100100: begin v = 4'h2; return 0; end
         7'b0110000: begin v = 4'h3; return 0; end
         7'b0011001: begin v = 4'h4; return 0; end
         7'b0010010: begin v = 4'h5; return 0; end
         7'b0000010: begin v = 4'h6; return 0; end
         7'b1111000: begin v = 4'h7; return 0; end
         7'b0000000: begin v = 4'h8; return 0; end
         7'b0010000: begin v = 4'h9; return 0; end
`ifdef SSG_SCAN_READER_HEX_EN
         7'b0001000: begin v = 4'hA; return 0; end
         7'b0000011: begin v = 4'hB; return 0; end
         7'b1000110: begin v = 4'hC; return 0; end
         7'b0100001: begin v = 4'hD; return 0; end
         7'b0000110: begin v = 4'hE; return 0; end
         7'b0001110: begin v = 4'hF; return 0; end
`endif
         7'b1111111: return 1;
         default:    return 2;
      endcase
   endfunction

   task automatic push_capture(input logic [3:0] en, input logic [6:0] d, input int due);
      logic [3:0] v;
      int         k;
      int         idx;
      exp_t       x;
      idx = 0;
      for (int i = 0; i < 4; i++) if (!en[i]) idx = i;
      k = ref_kind(d, v);
      if (k == 2) begin
         m_serr = 1'b1;
      end else begin
         m_dig[4*idx +: 4] = v;
         m_val[idx]        = (k == 0);
         m_seen[idx]       = 1'b1;
      end
      x.frame = (m_seen == 4'b1111);
      if (x.frame) m_seen = 4'b0000;
      x.due  = due;
      x.dig  = m_dig;
      x.val  = m_val;
      x.serr = m_serr;
      sbq.push_back(x);
   endtask

   // Drive one enable/pattern pair for n cycles; cap queues an expected capture.
   task automatic hold(input logic [3:0] en, input logic [6:0] d, input int n, input bit cap);
      @(negedge clk);
      SSG_EN = en;
      SSG_D  = d;
      if (cap) push_capture(en, d, cyc + STABLE + 1);
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      SSG_EN = 4'b1111;
      SSG_D  = 7'b1111111;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drain;
      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
      if (sbq.size() > 0) begin
         total++; bad++;
         $display("FAIL drain pending=%0d exp=0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1; SSG_EN = 4'b1111; SSG_D = 7'b1111111; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      m_dig  = 16'hFFFF; m_val = 4'b0000; m_seen = 4'b0000; m_serr = 1'b0;
      sbq.delete();
   endtask

   task automatic test_reset;
      int f0;
      do_reset();
      total += 5;
      if (digits !== 16'hFFFF) begin bad++; $display("FAIL rst_digits got=%h exp=ffff", digits); end
      if (digit_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", digit_valid); end
      if (seg_err !== 1'b0) begin bad++; $display("FAIL rst_seg_err got=%b exp=0", seg_err); end
      if (en_err !== 1'b0) begin bad++; $display("FAIL rst_en_err got=%b exp=0", en_err); end
      f0 = frames;
      idle(8);
      if (frames != f0) begin bad++; $display("FAIL rst_frame pulses=%0d exp=0", frames - f0); end
   endtask

   task automatic test_scan;
      int f0;
      f0 = frames;
      hold(4'b1110, 7'b1111001, 4, 1);
      hold(4'b1101, 7'b0100100, 4, 1);
      hold(4'b1011, 7'b0110000, 4, 1);
      hold(4'b0111, 7'b0011001, 4, 1);
      idle(4);
      drain();
      total += 2;
      if (digits !== 16'h4321) begin bad++; $display("FAIL scan_digits got=%h exp=4321", digits); end
      if (frames != f0 + 1) begin bad++; $display("FAIL scan_frames got=%0d exp=1", frames - f0); end
   endtask

   task automatic test_settle;
      saw5 = 0;
      hold(4'b1110, 7'b0010010, 3, 0);
      hold(4'b1110, 7'b0000010, 4, 1);
      idle(4);
      drain();
      total += 2;
      if (digits[3:0] !== 4'h6) begin bad++; $display("FAIL settle_digit0 got=%h exp=6", digits[3:0]); end
      if (saw5) begin bad++; $display("FAIL settle_never5 got=1 exp=0"); end
   endtask

   task automatic test_blank;
      int f0;
      f0 = frames;
      hold(4'b1101, 7'b1111111, 4, 1);
      hold(4'b1011, 7'b0010010, 4, 1);
      hold(4'b0111, 7'b1000000, 4, 1);
      idle(4);
      drain();
      total += 3;
      if (digits !== 16'h05F6) begin bad++; $display("FAIL blank_digits got=%h exp=05f6", digits); end
      if (digit_valid[1] !== 1'b0) begin bad++; $display("FAIL blank_valid1 got=%b exp=0", digit_valid[1]); end
      if (frames != f0 + 1) begin bad++; $display("FAIL blank_frames got=%0d exp=1", frames - f0); end
   endtask

   task automatic test_hex;
      hold(4'b1110, 7'b0001000, 4, 1);
      idle(4);
      drain();
      total++;
`ifdef SSG_SCAN_READER_HEX_EN
      if (digits[3:0] !== 4'hA) begin bad++; $display("FAIL hex_digit0 got=%h exp=a", digits[3:0]); end
`else
      if (digits[3:0] !== 4'h6) begin bad++; $display("FAIL hex_digit0 got=%h exp=6", digits[3:0]); end
`endif
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      m_serr = 1'b0;
      total++;
      if (seg_err !== 1'b0) begin bad++; $display("FAIL hex_clr got=%b exp=0", seg_err); end
   endtask

   task automatic test_no_recapture;
      hold(4'b1110, 7'b0101010, 6, 1);
      drain();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      m_serr = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (seg_err !== 1'b0) begin bad++; $display("FAIL norecap_seg_err got=%b exp=0", seg_err); end
      idle(2);
   endtask

   task automatic test_back_to_back;
      int f0;
      f0 = frames;
      hold(4'b1110, 7'b1111000, 4, 1);
      hold(4'b1110, 7'b0000000, 4, 1);
      idle(4);
      drain();
      total += 2;
      if (digits[3:0] !== 4'h8) begin bad++; $display("FAIL b2b_digit0 got=%h exp=8", digits[3:0]); end
      if (frames != f0) begin bad++; $display("FAIL b2b_frames got=%0d exp=0", frames - f0); end
   endtask

   task automatic test_collision;
      logic [3:0] d2;
      @(negedge clk); SSG_EN = 4'b1100; SSG_D = 7'b1111001;
      @(negedge clk); SSG_EN = 4'b1111; SSG_D = 7'b1111111;
      @(negedge clk);
      total++;
      if (en_err !== 1'b1) begin bad++; $display("FAIL coll_set got=%b exp=1", en_err); end
      hold(4'b1110, 7'b1111001, 4, 1);
      idle(4);
      drain();
      d2 = digits[11:8];
      hold(4'b1011, 7'b0100100, 2, 0);
      hold(4'b1100, 7'b0100100, 1, 0);
      hold(4'b1011, 7'b0100100, 3, 0);
      idle(6);
      total++;
      if (digits[11:8] !== d2) begin bad++; $display("FAIL coll_restart got=%h exp=%h", digits[11:8], d2); end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      total++;
      if (en_err !== 1'b0) begin bad++; $display("FAIL coll_clr got=%b exp=0", en_err); end
      @(negedge clk); SSG_EN = 4'b1100;
      @(negedge clk); SSG_EN = 4'b1111; err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      total++;
      if (en_err !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", en_err); end
      @(negedge clk);
      total++;
      if (en_err !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%b exp=1", en_err); end
   endtask

   task automatic test_reset_mid_settle;
      hold(4'b1011, 7'b0010000, 2, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; SSG_EN = 4'b1111; SSG_D = 7'b1111111;
      m_dig = 16'hFFFF; m_val = 4'b0000; m_seen = 4'b0000; m_serr = 1'b0;
      repeat (8) @(negedge clk);
      total += 3;
      if (digits !== 16'hFFFF) begin bad++; $display("FAIL midrst_digits got=%h exp=ffff", digits); end
      if (digit_valid !== 4'b0000) begin bad++; $display("FAIL midrst_valid got=%b exp=0000", digit_valid); end
      if (en_err !== 1'b0) begin bad++; $display("FAIL midrst_en_err got=%b exp=0", en_err); end
   endtask

   initial begin
      reset   = 1'b1;
      err_clr = 1'b0;
      SSG_EN  = 4'b1111;
      SSG_D   = 7'b1111111;
      test_reset();
      test_scan();
      test_settle();
      test_blank();
      test_hex();
      test_no_recapture();
      test_back_to_back();
      test_collision();
      test_reset_mid_settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
